// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and defaults for the program-counter fetch sequencer.
package pc_fetch_sequencer_pkg;
  localparam int          DEF_ADDR_W      = 32;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;
  localparam int          DEF_INSTR_BYTES = 4;

  typedef logic [DEF_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_HALT  = 2'd1,
    S_ISSUE = 2'd2,
    S_REQ   = 2'd3
  } pc_state_e;
endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Start-up control, fetch handshake and decode-side pc signals of the sequencer.
interface pc_fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              enable;
  logic              clear_pc;
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              running;

  modport master (
    input  enable, clear_pc, stall, br_taken, br_target, fetch_ack,
    output fetch_req, fetch_addr, pc, pc_valid, running
  );

  modport slave (
    output enable, clear_pc, stall, br_taken, br_target, fetch_ack,
    input  fetch_req, fetch_addr, pc, pc_valid, running
  );
endinterface

// File: rtl/pc_fetch_sequencer_next.sv
// Next-address arithmetic: aligns a redirect target and forms the sequential successor.
module pc_next_calc #(
  parameter int ADDR_W      = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              redirect_i,
  output logic [ADDR_W-1:0] aligned_target_o,
  output logic [ADDR_W-1:0] next_o
);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_BYTES);

  // Sequential increment wraps silently at the top of the address space.
  assign aligned_target_o = target_i & ~LOW_MASK;
  assign next_o           = redirect_i ? aligned_target_o : base_i + STEP;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Turns enable/clear_pc into a running pc with a one-outstanding instruction fetch handshake.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES
) (
  input logic                  clk,
  input logic                  rst,
  pc_fetch_sequencer_if.master bus_if
);
  pc_state_e         state_q, state_d;
  logic              fetch_req_q, fetch_req_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              squash_q, squash_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] target_al;
  logic [ADDR_W-1:0] calc_next;

  pc_next_calc #(.ADDR_W(ADDR_W), .INSTR_BYTES(INSTR_BYTES)) u_next (
    .base_i           (fetch_addr_q),
    .target_i         (bus_if.br_target),
    .redirect_i       (bus_if.br_taken),
    .aligned_target_o (target_al),
    .next_o           (calc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= RESET_VEC;
      pc_q         <= RESET_VEC;
      pc_valid_q   <= 1'b0;
      squash_q     <= 1'b0;
      next_addr_q  <= RESET_VEC;
    end else begin
      state_q      <= state_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      squash_q     <= squash_d;
      next_addr_q  <= next_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    pc_valid_d   = 1'b0;
    squash_d     = squash_q;
    next_addr_d  = next_addr_q;

    if (bus_if.clear_pc) begin
      state_d     = S_CLEAR;
      fetch_req_d = 1'b0;
      squash_d    = 1'b0;
      next_addr_d = RESET_VEC;
      pc_d        = RESET_VEC;
    end else begin
      unique case (state_q)
        S_CLEAR: state_d = bus_if.enable ? S_ISSUE : S_HALT;
        S_HALT: begin
          if (bus_if.br_taken) next_addr_d = target_al;
          if (bus_if.enable)   state_d     = S_ISSUE;
        end
        S_ISSUE: begin
          // A redirect consumes the issue slot so the stale next_addr is never fetched.
          if (bus_if.br_taken) next_addr_d = target_al;
          if (!bus_if.enable) begin
            state_d = S_HALT;
          end else if (!bus_if.br_taken && !bus_if.stall) begin
            fetch_req_d  = 1'b1;
            fetch_addr_d = next_addr_q;
            state_d      = S_REQ;
          end
        end
        S_REQ: begin
          if (bus_if.fetch_ack) begin
            fetch_req_d = 1'b0;
            squash_d    = 1'b0;
            if (!squash_q && !bus_if.br_taken) begin
              pc_d       = fetch_addr_q;
              pc_valid_d = 1'b1;
            end
            // A redirect taken earlier in this request already sits in next_addr.
            if (!(squash_q && !bus_if.br_taken)) next_addr_d = calc_next;
            state_d = bus_if.enable ? S_ISSUE : S_HALT;
          end else if (bus_if.br_taken) begin
            squash_d    = 1'b1;
            next_addr_d = target_al;
          end
        end
        default: state_d = S_CLEAR;
      endcase
    end
  end

  assign bus_if.fetch_req  = fetch_req_q;
  assign bus_if.fetch_addr = fetch_addr_q;
  assign bus_if.pc         = pc_q;
  assign bus_if.pc_valid   = pc_valid_q;
  assign bus_if.running    = (state_q == S_ISSUE) || (state_q == S_REQ);
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed scenarios followed by randomized traffic checked against a transaction-level model.
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  pc_fetch_sequencer_if #(.ADDR_W(32)) bus ();

  pc_fetch_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse-level view of one fetch: request appears, ack one cycle later, pc delivered.
  task automatic do_fetch(input logic [31:0] addr);
    step();
    chk("req_up", bus.fetch_req, 1'b1);
    chk("req_addr", bus.fetch_addr, addr);
    chk("no_vld_on_issue", bus.pc_valid, 1'b0);
    bus.fetch_ack = 1'b1;
    step();
    bus.fetch_ack = 1'b0;
    chk("vld", bus.pc_valid, 1'b1);
    chk("pc", bus.pc, addr);
    chk("req_down", bus.fetch_req, 1'b0);
  endtask

  logic        m_out, m_squash, m_pv, m_br, m_stall, m_ack;
  logic [31:0] m_addr, m_next, m_pc, m_tgt;

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.clear_pc = 1'b0; bus.stall = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.fetch_ack = 1'b0;
    step(); step();
    chk("rst_req", bus.fetch_req, 1'b0);
    chk("rst_addr", bus.fetch_addr, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_vld", bus.pc_valid, 1'b0);
    chk("rst_run", bus.running, 1'b0);

    // Clear held for four cycles with enable already high.
    rst = 1'b0; bus.clear_pc = 1'b1; bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("clr_req", bus.fetch_req, 1'b0);
      chk("clr_run", bus.running, 1'b0);
    end
    bus.clear_pc = 1'b0;
    step();
    chk("issue_run", bus.running, 1'b1);
    chk("issue_req", bus.fetch_req, 1'b0);
    do_fetch(32'h0); do_fetch(32'h4); do_fetch(32'h8); do_fetch(32'hC);

    // Branch while 0x10 is outstanding: 0x10 squashed, 0x100 fetched next.
    step();
    chk("br_req", bus.fetch_addr, 32'h10);
    bus.br_taken = 1'b1; bus.br_target = 32'h101;
    step();
    bus.br_taken = 1'b0;
    chk("br_hold", bus.fetch_req, 1'b1);
    bus.fetch_ack = 1'b1;
    step();
    bus.fetch_ack = 1'b0;
    chk("sq_vld", bus.pc_valid, 1'b0);
    chk("sq_pc", bus.pc, 32'hC);
    do_fetch(32'h100);

    // Stall for three cycles in the issue state.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req", bus.fetch_req, 1'b0);
      chk("stall_addr", bus.fetch_addr, 32'h100);
    end
    bus.stall = 1'b0;
    do_fetch(32'h104);

    // Enable dropped while 0x108 outstanding: request completes, then halt.
    step();
    chk("en_req", bus.fetch_addr, 32'h108);
    bus.enable = 1'b0;
    step();
    chk("en_hold", bus.fetch_req, 1'b1);
    bus.fetch_ack = 1'b1;
    step();
    bus.fetch_ack = 1'b0;
    chk("en_vld", bus.pc_valid, 1'b1);
    chk("en_pc", bus.pc, 32'h108);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_req", bus.fetch_req, 1'b0);
      chk("halt_run", bus.running, 1'b0);
    end
    bus.enable = 1'b1;
    step();
    do_fetch(32'h10C);

    // Clear mid-request, then a stray ack.
    step();
    chk("clrm_req", bus.fetch_addr, 32'h110);
    bus.clear_pc = 1'b1;
    step();
    bus.clear_pc = 1'b0; bus.fetch_ack = 1'b1;
    chk("clrm_drop", bus.fetch_req, 1'b0);
    chk("clrm_pc", bus.pc, 32'h0);
    step();
    bus.fetch_ack = 1'b0;
    chk("stray_vld", bus.pc_valid, 1'b0);
    chk("stray_req", bus.fetch_req, 1'b0);
    do_fetch(32'h0);

    // Preload the top word via a branch in the issue state, then wrap.
    bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFE;
    step();
    bus.br_taken = 1'b0;
    chk("wbr_req", bus.fetch_req, 1'b0);
    do_fetch(32'hFFFF_FFFC);
    do_fetch(32'h0);

    // Randomized traffic from a freshly cleared, enabled sequencer.
    bus.clear_pc = 1'b1;
    step();
    bus.clear_pc = 1'b0;
    step();
    m_out = 1'b0; m_squash = 1'b0; m_addr = 32'h0; m_next = 32'h0; m_pc = 32'h0;
    for (int c = 0; c < 400; c++) begin
      m_stall = ($urandom_range(0, 2) == 0);
      m_br    = ($urandom_range(0, 5) == 0);
      m_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
      m_ack   = m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      bus.stall = m_stall; bus.br_taken = m_br; bus.br_target = m_tgt; bus.fetch_ack = m_ack;
      m_pv = 1'b0;
      if (m_out) begin
        if (m_ack) begin
          if (!m_squash && !m_br) begin
            m_pv = 1'b1;
            m_pc = m_addr;
          end
          if (m_br)           m_next = m_tgt & ~32'h3;
          else if (!m_squash) m_next = m_addr + 32'd4;
          m_out = 1'b0; m_squash = 1'b0;
        end else if (m_br) begin
          m_squash = 1'b1;
          m_next   = m_tgt & ~32'h3;
        end
      end else if (m_br) begin
        m_next = m_tgt & ~32'h3;
      end else if (!m_stall) begin
        m_out  = 1'b1;
        m_addr = m_next;
      end
      step();
      chk("rnd_req", bus.fetch_req, m_out);
      chk("rnd_vld", bus.pc_valid, m_pv);
      chk("rnd_pc", bus.pc, m_pc);
      chk("rnd_run", bus.running, 1'b1);
      if (m_out) chk("rnd_addr", bus.fetch_addr, m_addr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
